// File: rtl/div_sched_pkg.sv
// Shared types and width helpers for the divider scheduler and its response buffers.
package div_sched_pkg;

  localparam int IDX_W_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic [IDX_W_MAX-1:0] idx;
    logic                 dbz;
  } div_tag_t;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_rsp_fifo.sv
// Per-requester response buffer: circular FIFO, head shown combinationally, zeros when empty.
module div_rsp_fifo
  import div_sched_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int RSP_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] push_q,
  input  logic [DATAWIDTH-1:0] push_r,
  input  logic                 push_dbz,
  input  logic                 pop,
  output logic                 valid,
  output logic [DATAWIDTH-1:0] head_q,
  output logic [DATAWIDTH-1:0] head_r,
  output logic                 head_dbz
);

  localparam int PTR_W = idx_width(RSP_DEPTH);
  localparam int CNT_W = credit_width(RSP_DEPTH);

  logic [2*DATAWIDTH:0] mem [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 do_pop;
  logic                 do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(RSP_DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_dbz, push_q, push_r};
  end

  assign valid    = (count != '0);
  assign head_dbz = valid ? mem[rd_ptr][2*DATAWIDTH] : 1'b0;
  assign head_q   = valid ? mem[rd_ptr][2*DATAWIDTH-1:DATAWIDTH] : '0;
  assign head_r   = valid ? mem[rd_ptr][DATAWIDTH-1:0] : '0;

endmodule

// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one pipelined divider among NUM_REQ requesters,
// with credit-based per-requester response buffering and a sticky protocol error.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 3,
  parameter int RSP_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [NUM_REQ*DATAWIDTH-1:0] rsp_q,
  output logic [NUM_REQ*DATAWIDTH-1:0] rsp_r,
  output logic [NUM_REQ-1:0]           rsp_dbz,
  output logic                         div_i_valid,
  output logic [DATAWIDTH-1:0]         div_a,
  output logic [DATAWIDTH-1:0]         div_b,
  input  logic                         div_o_valid,
  input  logic [DATAWIDTH-1:0]         div_q,
  input  logic [DATAWIDTH-1:0]         div_r,
  output logic                         err
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CRD_W = credit_width(RSP_DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // ready never waits on anything registered inside the requester, only on credits.
  logic [CRD_W-1:0]     credit [NUM_REQ];
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand;
  logic                 grant_any;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant_vec;
  logic [NUM_REQ-1:0]   pop_vec;
  logic [NUM_REQ-1:0]   push_vec;
  logic [NUM_REQ-1:0]   fifo_valid;
  logic [NUM_REQ-1:0]   fifo_dbz;
  logic [DATAWIDTH-1:0] fifo_q [NUM_REQ];
  logic [DATAWIDTH-1:0] fifo_r [NUM_REQ];
  div_tag_t             tag_sr [LATENCY];
  div_tag_t             tag_in;
  div_tag_t             tag_out;
  logic                 err_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) eligible[i] = req_valid[i] && (credit[i] != '0);
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (rst) grant_any = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) grant_vec[i] = grant_any && (grant_idx == IDX_W'(i));
  end

  assign req_ready   = grant_vec;
  assign div_i_valid = grant_any;
  assign div_a       = grant_any ? req_a[grant_idx*DATAWIDTH +: DATAWIDTH] : '0;
  assign div_b       = grant_any ? req_b[grant_idx*DATAWIDTH +: DATAWIDTH] : '0;

  always_comb begin
    tag_in                  = '0;
    tag_in.valid            = grant_any;
    tag_in.idx[IDX_W-1:0]   = grant_idx;
    tag_in.dbz              = grant_any && (div_b == '0);
  end

  assign tag_out = tag_sr[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) tag_sr[k] <= '0;
    end else begin
      tag_sr[0] <= tag_in;
      for (int k = 1; k < LATENCY; k++) tag_sr[k] <= tag_sr[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant_any) rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (div_o_valid != tag_out.valid) err_q <= 1'b1;
    end
  end

  // Credits count free buffer slots minus operations already in the divider.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        credit[i] <= CRD_W'(RSP_DEPTH);
      end else begin
        case ({grant_vec[i], pop_vec[i]})
          2'b10:   if (credit[i] != '0) credit[i] <= credit[i] - 1'b1;
          2'b01:   if (credit[i] != CRD_W'(RSP_DEPTH)) credit[i] <= credit[i] + 1'b1;
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  assign pop_vec = rsp_valid & rsp_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign push_vec[i] = tag_out.valid && div_o_valid && (tag_out.idx == IDX_W_MAX'(i));

    div_rsp_fifo #(
      .DATAWIDTH(DATAWIDTH),
      .RSP_DEPTH(RSP_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_vec[i]),
      .push_q   (div_q),
      .push_r   (div_r),
      .push_dbz (tag_out.dbz),
      .pop      (pop_vec[i]),
      .valid    (fifo_valid[i]),
      .head_q   (fifo_q[i]),
      .head_r   (fifo_r[i]),
      .head_dbz (fifo_dbz[i])
    );

    assign rsp_valid[i]                     = fifo_valid[i] && !rst;
    assign rsp_dbz[i]                       = fifo_dbz[i] && !rst;
    assign rsp_q[i*DATAWIDTH +: DATAWIDTH]  = rst ? '0 : fifo_q[i];
    assign rsp_r[i*DATAWIDTH +: DATAWIDTH]  = rst ? '0 : fifo_r[i];
  end

  assign err = err_q && !rst;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler with an attached pipelined divider model.
module tb_div_scheduler;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam int DEP = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready;
  logic [NR*DW-1:0] rsp_q;
  logic [NR*DW-1:0] rsp_r;
  logic [NR-1:0]   rsp_dbz;
  logic            div_i_valid;
  logic [DW-1:0]   div_a;
  logic [DW-1:0]   div_b;
  logic            div_o_valid;
  logic [DW-1:0]   div_q;
  logic [DW-1:0]   div_r;
  logic            err;
  logic            force_ov;

  int total = 0;
  int bad   = 0;

  logic [2*DW:0] exp_q [NR][$];

  always #5 clk = ~clk;

  div_scheduler #(.DATAWIDTH(DW), .NUM_REQ(NR), .LATENCY(LAT), .RSP_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_dbz(rsp_dbz),
    .div_i_valid(div_i_valid), .div_a(div_a), .div_b(div_b),
    .div_o_valid(div_o_valid), .div_q(div_q), .div_r(div_r),
    .err(err)
  );

  // Divider model: LAT-stage pipeline; divide by zero yields all-ones quotient, remainder = dividend.
  logic          mv [LAT];
  logic [DW-1:0] mq [LAT];
  logic [DW-1:0] mr [LAT];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) mv[k] <= 1'b0;
    end else begin
      mv[0] <= div_i_valid;
      mq[0] <= (div_b == 0) ? 8'hFF : div_a / div_b;
      mr[0] <= (div_b == 0) ? div_a : div_a % div_b;
      for (int k = 1; k < LAT; k++) begin
        mv[k] <= mv[k-1];
        mq[k] <= mq[k-1];
        mr[k] <= mr[k-1];
      end
    end
  end

  assign div_o_valid = mv[LAT-1] | force_ov;
  assign div_q       = mq[LAT-1];
  assign div_r       = mr[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*DW:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (b == 0) return {1'b1, 8'hFF, a};
    return {1'b0, DW'(a / b), DW'(a % b)};
  endfunction

  // Scoreboard: expectations enter on accepted requests, leave on consumed responses.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i])
          exp_q[i].push_back(model(req_a[i*DW +: DW], req_b[i*DW +: DW]));
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("rsp_unexpected_%0d", i), 32'(rsp_valid[i]), 32'd0);
          end else begin
            check($sformatf("rsp_data_%0d", i),
                  32'({rsp_dbz[i], rsp_q[i*DW +: DW], rsp_r[i*DW +: DW]}),
                  32'(exp_q[i].pop_front()));
          end
        end
      end
      check("ready_wo_valid", 32'(req_ready & ~req_valid), 32'd0);
      check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[i]       = 1'b1;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = DW'($urandom_range(0, 255));
      req_b[i*DW +: DW] = DW'($urandom_range(0, 255));
    end
  endtask

  task automatic drain(input string name);
    req_valid = '0;
    rsp_ready = '1;
    repeat (10) tick();
    for (int i = 0; i < NR; i++) check($sformatf("%s_empty_%0d", name, i), 32'(exp_q[i].size()), 32'd0);
  endtask

  typedef struct {
    int            idx;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
  } vec_t;

  vec_t vecs [7];
  int   gcnt [NR];
  int   exp_next;
  int   lat;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    vecs[1] = '{2, 8'd55,  8'd0,   8'hFF,  8'd55, 1'b1};
    vecs[2] = '{1, 8'd200, 8'd13,  8'd15,  8'd5,  1'b0};
    vecs[3] = '{3, 8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    vecs[4] = '{0, 8'd9,   8'd10,  8'd0,   8'd9,  1'b0};
    vecs[5] = '{1, 8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
    vecs[6] = '{3, 8'd128, 8'd128, 8'd1,   8'd0,  1'b0};

    // Reset with requests pending: every output must stay 0.
    rst = 1'b1;
    force_ov = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    randomize_ops();
    repeat (2) tick();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_div_i_valid", 32'(div_i_valid), 32'd0);
    check("rst_div_a", 32'(div_a), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_q", 32'(rsp_q), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) tick();

    // Single operations: grant immediately, response in cycle t+4.
    for (int v = 0; v < 7; v++) begin
      set_req(vecs[v].idx, vecs[v].a, vecs[v].b);
      @(negedge clk);
      check($sformatf("vec%0d_grant", v), 32'(req_ready), 32'(1 << vecs[v].idx));
      check($sformatf("vec%0d_div_a", v), 32'(div_a), 32'(vecs[v].a));
      tick();
      req_valid = '0;
      lat = 0;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
        @(negedge clk);
        if (rsp_valid[vecs[v].idx]) begin
          lat = c;
          check($sformatf("vec%0d_q", v), 32'(rsp_q[vecs[v].idx*DW +: DW]), 32'(vecs[v].q));
          check($sformatf("vec%0d_r", v), 32'(rsp_r[vecs[v].idx*DW +: DW]), 32'(vecs[v].r));
          check($sformatf("vec%0d_dbz", v), 32'(rsp_dbz[vecs[v].idx]), 32'(vecs[v].dbz));
        end
      end
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd4);
      repeat (2) tick();
    end

    // All requesters busy: strict rotation, one response per cycle once the pipe fills.
    exp_next = (vecs[6].idx + 1) % NR;
    for (int cyc = 0; cyc < 24; cyc++) begin
      req_valid = '1;
      randomize_ops();
      @(negedge clk);
      check("rr_order", 32'(req_ready), 32'(1 << exp_next));
      exp_next = (exp_next + 1) % NR;
      if (cyc >= 4) check("no_bubble", 32'(|rsp_valid), 32'd1);
      tick();
    end
    drain("thru");

    // Requester 1 stalls on its response side: two grants, then others keep rotating.
    for (int i = 0; i < NR; i++) gcnt[i] = 0;
    rsp_ready = 4'b1101;
    for (int cyc = 0; cyc < 30; cyc++) begin
      req_valid = '1;
      randomize_ops();
      @(negedge clk);
      for (int i = 0; i < NR; i++) gcnt[i] += int'(req_ready[i]);
      tick();
    end
    @(negedge clk);
    check("stall_ready1", 32'(req_ready[1]), 32'd0);
    check("stall_grants1", 32'(gcnt[1]), 32'd2);
    check("stall_rsp_valid1", 32'(rsp_valid[1]), 32'd1);
    for (int i = 0; i < NR; i++)
      if (i != 1) check($sformatf("stall_svc_%0d", i), 32'(gcnt[i] >= 9), 32'd1);
    tick();
    drain("stall");

    // Reset with three operations in flight: they vanish and credits return.
    rsp_ready = '1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      req_valid = 4'b0111;
      randomize_ops();
      tick();
    end
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_err", 32'(err), 32'd0);
      tick();
    end
    for (int i = 0; i < NR; i++) gcnt[i] = 0;
    rsp_ready = '0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      req_valid = '1;
      randomize_ops();
      @(negedge clk);
      for (int i = 0; i < NR; i++) gcnt[i] += int'(req_ready[i]);
      tick();
    end
    for (int i = 0; i < NR; i++) check($sformatf("credit_after_rst_%0d", i), 32'(gcnt[i]), 32'(DEP));
    drain("rst");

    // Unsolicited divider output: sticky err from the next cycle, no buffer written.
    tick();
    force_ov = 1'b1;
    @(negedge clk);
    check("err_same_cycle", 32'(err), 32'd0);
    tick();
    force_ov = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);
      check("err_no_write", 32'(rsp_valid), 32'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err), 32'd0);
    tick();

    for (int i = 0; i < NR; i++) check($sformatf("final_empty_%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
